fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the instruction memory.
- Holds the PC and drives the memory word address.
- Accounts for the memory's 1-cycle synchronous read latency.
- Delivers instructions and their PCs to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush of in-flight and buffered fetches.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 81 ++++++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Constants shared by the instruction fetch stage and its output buffer:
// datapath width, default reset PC, instruction width and the NOP encoding
// used when inspecting the pipeline in a debugger.
`timescale 1ns/1ps
package fetch_unit_pkg;

    localparam int REG_WIDTH   = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR        = 32'h0000_0013;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Small synchronous FIFO buffering fetched {pc, instr} pairs in front of
// decode. The head is presented combinationally; an empty FIFO presents
// all-zero data so the outputs are defined straight out of reset.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   flush  in   drop all entries; wins over push and pop in the same cycle
//   push   in   write wdata at the tail
//   wdata  in   entry to write
//   pop    in   remove the head entry
//   rdata  out  head entry (zero when empty)
//   count  out  number of valid entries, 0..DEPTH
`timescale 1ns/1ps
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign do_push = push & ~flush & (count_reg != CW'(DEPTH));
    assign do_pop  = pop  & ~flush & (count_reg != '0);

    // Storage carries no reset; the empty gate on rdata hides stale words.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = (count_reg == '0) ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage in front of a synchronous instruction memory with
// one cycle of read latency. Holds the fetch PC, issues word addresses,
// captures the returning word one edge later and buffers {pc, instr} pairs
// for decode behind a valid/ready handshake. A redirect flushes the buffer
// and drops any in-flight response.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   iaddr           out  word address to memory (fetch_pc >> 2)
//   idata           in   memory read data, valid the cycle after iaddr sampled
//   fetch_en        in   0 = issue no new requests (in-flight still completes)
//   redirect_valid  in   single-cycle redirect request
//   redirect_pc     in   redirect target byte address, bits [1:0] ignored
//   instr_valid     out  buffer head valid
//   instr_ready     in   decode accepts the head
//   instr           out  instruction word at the head
//   instr_pc        out  byte PC of the head
`timescale 1ns/1ps
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  REG_SIZE   = REG_WIDTH,
    parameter logic [REG_SIZE-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int                  FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [REG_SIZE-1:0] iaddr,
    input  logic [REG_SIZE-1:0] idata,
    input  logic                fetch_en,
    input  logic                redirect_valid,
    input  logic [REG_SIZE-1:0] redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [REG_SIZE-1:0] instr,
    output logic [REG_SIZE-1:0] instr_pc
);

    localparam int CW = count_width(FIFO_DEPTH);

    logic [REG_SIZE-1:0]   fetch_pc_reg;
    logic [REG_SIZE-1:0]   req_pc_reg;
    logic                  inflight_reg;

    logic [CW-1:0]         fifo_count;
    logic [2*REG_SIZE-1:0] fifo_head;
    logic                  pop;
    logic                  fifo_pop;
    logic                  push;
    logic                  issue;
    logic [CW:0]           occupancy;

    assign pop = instr_valid & instr_ready;

    // Slots already claimed once this edge's pop is taken into account.
    // Issuing only while this is below the depth means every response that
    // comes back one edge later always has room in the buffer.
    assign occupancy = {1'b0, fifo_count}
                     + {{CW{1'b0}}, inflight_reg}
                     - {{CW{1'b0}}, pop};

    assign issue    = fetch_en & ~redirect_valid & (occupancy < (CW+1)'(FIFO_DEPTH));
    assign push     = inflight_reg & ~redirect_valid;
    // A handshake during a redirect is still consumed by decode; the flush
    // clears the buffer regardless, so the pop itself is simply dropped.
    assign fifo_pop = pop & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= '0;
            inflight_reg <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc & ~REG_SIZE'(3);
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                req_pc_reg   <= fetch_pc_reg;
                fetch_pc_reg <= fetch_pc_reg + REG_SIZE'(4);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2*REG_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({req_pc_reg, idata}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign iaddr       = fetch_pc_reg >> 2;
    assign instr_valid = (fifo_count != '0);
    assign instr       = fifo_head[REG_SIZE-1:0];
    assign instr_pc    = fifo_head[2*REG_SIZE-1:REG_SIZE];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Drives the fetch stage against a one-cycle-latency memory whose word k
// holds 0x1000_0000 + k. The reference is stream level: after reset the
// delivered PCs run 0, 4, 8 ...; after a redirect they restart at the
// aligned target. Each accepted instruction must match the next expected
// PC and the memory word at that PC.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] iaddr;
    logic [31:0] idata = 32'h0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_pc = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(
        .REG_SIZE   (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iaddr          (iaddr),
        .idata          (idata),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    // Synchronous instruction memory: word k = 0x1000_0000 + k.
    always @(posedge clk) idata <= 32'h1000_0000 + iaddr;

    // One line per accepted instruction.
    always @(posedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect_valid)
            $display("xfer pc=%h instr=%h", instr_pc, instr);
    end

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'h1000_0000 + (pc >> 2);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        step(); step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
        total++; if (iaddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL edge1_valid: got %b want 0", instr_valid); end
        total++; if (iaddr !== 32'h1) begin bad++; $display("FAIL edge1_iaddr: got %h want 1", iaddr); end
        step();
        exp_pc = 32'h0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stream_valid: got %b want 1", instr_valid); end
            total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL stream_pc: got %h want %h", instr_pc, exp_pc); end
            total++; if (instr !== word_of(exp_pc)) begin bad++; $display("FAIL stream_instr: got %h want %h", instr, word_of(exp_pc)); end
            total++; if (iaddr !== ((exp_pc + 32'd8) >> 2)) begin bad++; $display("FAIL stream_iaddr: got %h want %h", iaddr, (exp_pc + 32'd8) >> 2); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p;
        p = exp_pc;
        instr_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", instr_valid); end
            total++; if (instr_pc !== p) begin bad++; $display("FAIL bp_pc_stable: got %h want %h", instr_pc, p); end
            total++; if (instr !== word_of(p)) begin bad++; $display("FAIL bp_instr_stable: got %h want %h", instr, word_of(p)); end
            total++; if (iaddr !== ((p + 32'd8) >> 2)) begin bad++; $display("FAIL bp_iaddr_stop: got %h want %h", iaddr, (p + 32'd8) >> 2); end
            step();
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_resume_valid: got %b want 1", instr_valid); end
            total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL bp_resume_pc: got %h want %h", instr_pc, exp_pc); end
            total++; if (instr !== word_of(exp_pc)) begin bad++; $display("FAIL bp_resume_instr: got %h want %h", instr, word_of(exp_pc)); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_redirect_full();
        instr_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush_valid: got %b want 0", instr_valid); end
        total++; if (iaddr !== 32'h40) begin bad++; $display("FAIL redir_iaddr: got %h want 40", iaddr); end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_e1_valid: got %b want 0", instr_valid); end
        total++; if (iaddr !== 32'h41) begin bad++; $display("FAIL redir_e1_iaddr: got %h want 41", iaddr); end
        step();
        exp_pc = 32'h100;
        for (int i = 0; i < 4; i++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL redir_valid: got %b want 1", instr_valid); end
            total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL redir_pc: got %h want %h", instr_pc, exp_pc); end
            total++; if (instr !== word_of(exp_pc)) begin bad++; $display("FAIL redir_instr: got %h want %h", instr, word_of(exp_pc)); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_redirect_handshake();
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rh_head_valid: got %b want 1", instr_valid); end
        total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL rh_head_pc: got %h want %h", instr_pc, exp_pc); end
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
        step();
        redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rh_e0_valid: got %b want 0", instr_valid); end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rh_e1_valid: got %b want 0", instr_valid); end
        step();
        exp_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rh_valid: got %b want 1", instr_valid); end
            total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL rh_pc: got %h want %h", instr_pc, exp_pc); end
            total++; if (instr !== word_of(exp_pc)) begin bad++; $display("FAIL rh_instr: got %h want %h", instr, word_of(exp_pc)); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_fetch_en();
        logic [31:0] stop_addr;
        stop_addr = (exp_pc + 32'd8) >> 2;
        fetch_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL fe_drain_valid: got %b want 1", instr_valid); end
            total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL fe_drain_pc: got %h want %h", instr_pc, exp_pc); end
            total++; if (iaddr !== stop_addr) begin bad++; $display("FAIL fe_iaddr_hold: got %h want %h", iaddr, stop_addr); end
            exp_pc += 32'd4;
            step();
        end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fe_empty_valid: got %b want 0", instr_valid); end
        step();
        fetch_en = 1'b1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fe_reen_valid: got %b want 0", instr_valid); end
        total++; if (iaddr !== (exp_pc >> 2)) begin bad++; $display("FAIL fe_reen_iaddr: got %h want %h", iaddr, exp_pc >> 2); end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fe_wait_valid: got %b want 0", instr_valid); end
        step();
        for (int i = 0; i < 3; i++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL fe_resume_valid: got %b want 1", instr_valid); end
            total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL fe_resume_pc: got %h want %h", instr_pc, exp_pc); end
            total++; if (instr !== word_of(exp_pc)) begin bad++; $display("FAIL fe_resume_instr: got %h want %h", instr, word_of(exp_pc)); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", instr_valid); end
        total++; if (iaddr !== 32'h0) begin bad++; $display("FAIL areset_iaddr: got %h want 0", iaddr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL areset_pc: got %h want 0", instr_pc); end
        step();
        rst_n = 1'b1;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL areset_hold_valid: got %b want 0", instr_valid); end
        step();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL areset_e1_valid: got %b want 0", instr_valid); end
        total++; if (iaddr !== 32'h1) begin bad++; $display("FAIL areset_e1_iaddr: got %h want 1", iaddr); end
        step();
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL areset_valid_seq: got %b want 1", instr_valid); end
            total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL areset_pc_seq: got %h want %h", instr_pc, exp_pc); end
            total++; if (instr !== word_of(exp_pc)) begin bad++; $display("FAIL areset_instr_seq: got %h want %h", instr, word_of(exp_pc)); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step(); step();
        exp_pc = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %b want 1", instr_valid); end
            total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL wrap_pc: got %h want %h", instr_pc, exp_pc); end
            total++; if (instr !== word_of(exp_pc)) begin bad++; $display("FAIL wrap_instr: got %h want %h", instr, word_of(exp_pc)); end
            exp_pc += 32'd4;
            step();
        end
    endtask

    task automatic test_random();
        logic        prev_hold;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        int          waited;
        prev_hold = 1'b0; prev_pc = 32'h0; prev_instr = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            fetch_en       = ($urandom_range(0, 99) < 80);
            instr_ready    = ($urandom_range(0, 99) < 65);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc    = $urandom;
            if (prev_hold) begin
                total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rnd_hold_valid: got %b want 1", instr_valid); end
                total++; if (instr_pc !== prev_pc) begin bad++; $display("FAIL rnd_hold_pc: got %h want %h", instr_pc, prev_pc); end
                total++; if (instr !== prev_instr) begin bad++; $display("FAIL rnd_hold_instr: got %h want %h", instr, prev_instr); end
            end
            total++;
            if (dut.push && (dut.fifo_count == 2'd2) && !dut.fifo_pop) begin
                bad++; $display("FAIL rnd_overflow: got push into full buffer at pc %h want none", dut.req_pc_reg);
            end
            if (instr_valid && instr_ready) begin
                total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL rnd_pc: got %h want %h", instr_pc, exp_pc); end
                total++; if (instr !== word_of(exp_pc)) begin bad++; $display("FAIL rnd_instr: got %h want %h", instr, word_of(exp_pc)); end
                exp_pc += 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
            prev_hold  = instr_valid & ~instr_ready & ~redirect_valid;
            prev_pc    = instr_pc;
            prev_instr = instr;
            step();
        end
        fetch_en = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
        waited = 0;
        while (!instr_valid && waited < 10) begin
            step();
            waited++;
        end
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rnd_liveness: got valid %b after %0d cycles want 1", instr_valid, waited); end
        total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL rnd_final_pc: got %h want %h", instr_pc, exp_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_handshake();
        test_fetch_en();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
